// File: rtl/pc_exception_ctrl.sv
// rtl/pc_exception_ctrl.sv - PC/EPC register owner with exception vector-fetch FSM.
// Optional feature: define EXC_TIMEOUT_EN to bound the vector fetch wait.
module pc_exception_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] EXC_TABLE_BASE = 32'd253,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc_address,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero_flag,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        mem_read_req,
  output logic [31:0] mem_addr,
  output logic        exc_busy,
  output logic [1:0]  exc_cause,
  output logic        exc_done
);

  typedef enum logic [1:0] {IDLE, SAVE, FETCH, LOAD} state_t;

  state_t     state;
  logic [7:0] vector;
  logic       exc_any;
  logic [1:0] exc_sel;

  assign exc_any = exc_opcode | exc_overflow | exc_div0;
  assign exc_sel = exc_opcode ? 2'd0 : (exc_overflow ? 2'd1 : 2'd2);

`ifdef EXC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      epc          <= 32'd0;
      exc_cause    <= 2'd0;
      mem_read_req <= 1'b0;
      mem_addr     <= 32'd0;
      exc_busy     <= 1'b0;
      exc_done     <= 1'b0;
      vector       <= 8'd0;
`ifdef EXC_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          exc_done <= 1'b0;
          // An exception request wins over any PC write in the same cycle.
          if (exc_any) begin
            exc_cause <= exc_sel;
            exc_busy  <= 1'b1;
            state     <= SAVE;
          end else if (pc_write | (pc_write_cond & zero_flag)) begin
            pc <= next_pc_address;
          end
        end
        SAVE: begin
          epc          <= pc - 32'd4;
          mem_addr     <= EXC_TABLE_BASE + {30'd0, exc_cause};
          mem_read_req <= 1'b1;
          state        <= FETCH;
`ifdef EXC_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
        end
        FETCH: begin
          if (mem_valid) begin
            vector       <= mem_rdata;
            mem_read_req <= 1'b0;
            exc_done     <= 1'b1;
            state        <= LOAD;
          end
`ifdef EXC_TIMEOUT_EN
          // Abandon the fetch and restart from the reset vector.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            pc           <= RESET_PC;
            mem_read_req <= 1'b0;
            exc_done     <= 1'b1;
            exc_busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        LOAD: begin
          pc       <= {24'd0, vector};
          exc_done <= 1'b0;
          exc_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_exception_ctrl.sv
// tb/tb_pc_exception_ctrl.sv - directed and randomized checks of pc_exception_ctrl against a sequence model.
module tb_pc_exception_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BASE     = 32'd253;
  localparam int          TMO      = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] next_pc_address = '0;
  logic        pc_write = 0, pc_write_cond = 0, zero_flag = 0;
  logic        exc_opcode = 0, exc_overflow = 0, exc_div0 = 0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_valid = 0;
  logic [31:0] pc, epc, mem_addr;
  logic        mem_read_req, exc_busy, exc_done;
  logic [1:0]  exc_cause;

  pc_exception_ctrl dut (
    .clk(clk), .reset_n(reset_n), .next_pc_address(next_pc_address),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero_flag(zero_flag),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .pc(pc), .epc(epc),
    .mem_read_req(mem_read_req), .mem_addr(mem_addr), .exc_busy(exc_busy),
    .exc_cause(exc_cause), .exc_done(exc_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted exception is a sequence of edges since acceptance:
  // 1 = save done, then fetch edges until data (or timeout), then one load edge.
  logic [31:0] m_pc = RESET_PC, m_epc = 0, m_addr = 0;
  logic [1:0]  m_cause = 0;
  logic        m_req = 0, m_busy = 0, m_done = 0;
  logic [7:0]  m_vec = 0;
  int          seq = 0;
  int          fetch_waits = 0;

  always @(posedge clk or negedge reset_n) begin
    logic [2:0] reqs;
    if (!reset_n) begin
      m_pc = RESET_PC; m_epc = 0; m_addr = 0; m_cause = 0;
      m_req = 0; m_busy = 0; m_done = 0; seq = 0; fetch_waits = 0;
    end else begin
      m_done = 0;
      if (seq == 0) begin
        reqs = {exc_div0, exc_overflow, exc_opcode};
        if (reqs != 0) begin
          for (int i = 2; i >= 0; i--) if (reqs[i]) m_cause = 2'(i);
          m_busy = 1; seq = 1;
        end else if (pc_write || (pc_write_cond && zero_flag)) begin
          m_pc = next_pc_address;
        end
      end else if (seq == 1) begin
        m_epc = m_pc - 32'd4;
        m_addr = BASE + 32'(m_cause);
        m_req = 1; seq = 2; fetch_waits = 0;
      end else if (seq == 2) begin
        if (mem_valid) begin
          m_vec = mem_rdata; m_req = 0; m_done = 1; seq = 3;
        end else begin
          fetch_waits++;
`ifdef EXC_TIMEOUT_EN
          if (fetch_waits == TMO) begin
            m_pc = RESET_PC; m_req = 0; m_done = 1; m_busy = 0; seq = 0;
          end
`endif
        end
      end else begin
        m_pc = {24'd0, m_vec}; m_busy = 0; seq = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("mem_read_req", 32'(mem_read_req), 32'(m_req));
      chk("mem_addr", mem_addr, m_addr);
      chk("exc_busy", 32'(exc_busy), 32'(m_busy));
      chk("exc_cause", 32'(exc_cause), 32'(m_cause));
      chk("exc_done", 32'(exc_done), 32'(m_done));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_in();
    pc_write = 0; pc_write_cond = 0; zero_flag = 0;
    exc_opcode = 0; exc_overflow = 0; exc_div0 = 0; mem_valid = 0;
  endtask

  initial begin
    cmp_en = 1;
    step(); step();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_epc", epc, 32'd0);
    chk("rst_busy", 32'(exc_busy), 32'd0);
    chk("rst_req", 32'(mem_read_req), 32'd0);
    reset_n = 1;

    // Unconditional and conditional writes
    pc_write = 1; next_pc_address = 32'h10;
    step(); chk("t1_pc", pc, 32'h10); chk("t1_epc", epc, 32'd0);
    pc_write = 0; pc_write_cond = 1; zero_flag = 0; next_pc_address = 32'h40;
    step(); chk("t2_nz_pc", pc, 32'h10);
    zero_flag = 1;
    step(); chk("t2_z_pc", pc, 32'h40);
    clear_in();

    // Overflow exception with vector after one fetch cycle
    pc_write = 1; next_pc_address = 32'h104;
    step(); clear_in();
    exc_overflow = 1;
    step(); exc_overflow = 0; chk("t3_busy", 32'(exc_busy), 32'd1);
    step();
    chk("t3_epc", epc, 32'h100); chk("t3_addr", mem_addr, 32'd254);
    chk("t3_req", 32'(mem_read_req), 32'd1);
    mem_valid = 1; mem_rdata = 8'h7C;
    step(); mem_valid = 0;
    chk("t3_done", 32'(exc_done), 32'd1); chk("t3_req_drop", 32'(mem_read_req), 32'd0);
    step();
    chk("t3_pc", pc, 32'h7C); chk("t3_done_end", 32'(exc_done), 32'd0);
    chk("t3_cause", 32'(exc_cause), 32'd1); chk("t3_idle", 32'(exc_busy), 32'd0);

    // Simultaneous requests with pc_write, from pc=0
    pc_write = 1; next_pc_address = 32'h0;
    step();
    exc_opcode = 1; exc_div0 = 1; pc_write = 1; next_pc_address = 32'h55;
    step(); clear_in();
    chk("t4_pc_held", pc, 32'h0);
    step();
    chk("t4_epc", epc, 32'hFFFF_FFFC); chk("t4_addr", mem_addr, 32'd253);
    chk("t4_cause", 32'(exc_cause), 32'd0);

    // Requests while fetching are ignored, then async reset aborts
    exc_div0 = 1; pc_write = 1; next_pc_address = 32'h99;
    step(); clear_in();
    chk("t5_cause", 32'(exc_cause), 32'd0); chk("t5_pc", pc, 32'h0);
    chk("t5_req", 32'(mem_read_req), 32'd1);
    #2 reset_n = 0;
    #1;
    chk("t5_rst_req", 32'(mem_read_req), 32'd0); chk("t5_rst_pc", pc, RESET_PC);
    chk("t5_rst_busy", 32'(exc_busy), 32'd0);
    @(negedge clk); reset_n = 1;

`ifdef EXC_TIMEOUT_EN
    pc_write = 1; next_pc_address = 32'h200;
    step(); clear_in();
    exc_div0 = 1;
    step(); exc_div0 = 0;
    step();
    for (int i = 0; i < TMO; i++) step();
    chk("t6_pc", pc, RESET_PC); chk("t6_done", 32'(exc_done), 32'd1);
    chk("t6_busy", 32'(exc_busy), 32'd0); chk("t6_epc", epc, 32'h1FC);
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      next_pc_address = $urandom;
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      zero_flag     = $urandom_range(0, 1);
      exc_opcode    = ($urandom_range(0, 15) == 0);
      exc_overflow  = ($urandom_range(0, 15) == 0);
      exc_div0      = ($urandom_range(0, 15) == 0);
      mem_valid     = ($urandom_range(0, 3) == 0);
      mem_rdata     = 8'($urandom);
    end
    @(negedge clk);
    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
